rtsnoc_wishbone_master: RTL and testbench

//  NoC-to-Wishbone bridge: pops request packets from an RTSNoC router port, runs one
//  32-bit Wishbone master cycle per request, returns a response packet to the requester.

---
 rtl/rtsnoc_wishbone_master.sv | 248 ++++++++++++++++++++++++
 tb/tb_rtsnoc_wishbone_master.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtsnoc_wishbone_master.sv
// -----------------------------------------------------------------------------
// rtsnoc_wishbone_master
//   Bridge from an RTSNoC router port to a 32-bit Wishbone master. It pops a
//   request packet (CMD, ADR_LO, ADR_HI and, for writes, DAT_LO, DAT_HI), runs
//   one single Wishbone transfer, then sends a response packet back to the
//   requesting node: a status flit, followed by two data flits for a
//   successful read.
//
// Ports
//   clk_i, rst_i       clock, synchronous active-high reset
//   wb_*               Wishbone master (cyc/stb/adr/sel/we/dat_o, dat_i/ack_i)
//   noc_dout_i         flit from the router  {X_o,Y_o,L_o,X_d,Y_d,L_d,data[15:0]}
//   noc_nd_i           the router holds a valid flit on noc_dout_i
//   noc_rd_o           pop pulse, one cycle per flit taken
//   noc_din_o          flit to the router, same layout, unused MSBs zero
//   noc_wr_o           push pulse, one cycle per flit handed over
//   noc_wait_i         the router cannot accept a flit this cycle
//   busy_o             a request is in progress
// -----------------------------------------------------------------------------
module rtsnoc_wishbone_master #(
  parameter int NOC_LOCAL_ADR = 0,
  parameter int NOC_X         = 0,
  parameter int NOC_Y         = 0,
  parameter int SOC_SIZE_X    = 1,
  parameter int SOC_SIZE_Y    = 1,
  parameter int WB_TIMEOUT    = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic [37:0] noc_din_o,
  output logic        noc_wr_o,
  output logic        noc_rd_o,
  input  logic [37:0] noc_dout_i,
  input  logic        noc_wait_i,
  input  logic        noc_nd_i,
  output logic        busy_o
);

  localparam int NODE_W = SOC_SIZE_X + SOC_SIZE_Y + 3;
  localparam int FLIT_W = 2 * NODE_W + 16;
  localparam int CNT_W  = $clog2(WB_TIMEOUT + 1);

  localparam logic [NODE_W-1:0] OWN_NODE =
    {SOC_SIZE_X'(NOC_X), SOC_SIZE_Y'(NOC_Y), 3'(NOC_LOCAL_ADR)};
  localparam logic [15:0] STATUS_OK  = 16'h0001;
  localparam logic [15:0] STATUS_ERR = 16'h0002;

  typedef enum logic [3:0] {
    RX_CMD, RX_ALO, RX_AHI, RX_DLO, RX_DHI, WB, TX_ST, TX_DLO, TX_DHI
  } state_e;

  state_e             state_q, state_d;
  logic [NODE_W-1:0]  orig_q, orig_d;     // requester, response destination
  logic               cyc_q, cyc_d;
  logic               stb_q, stb_d;
  logic [31:0]        adr_q, adr_d;
  logic [3:0]         sel_q, sel_d;
  logic               we_q, we_d;
  logic [31:0]        dat_q, dat_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [37:0]        din_q, din_d;
  logic               gap_q, gap_d;       // handshake just fired last cycle

  logic [NODE_W-1:0]  in_orig;
  logic [15:0]        in_data;
  logic [37:0]        unused_dout;        // destination field and spare MSBs

  assign in_orig     = noc_dout_i[16+NODE_W +: NODE_W];
  assign in_data     = noc_dout_i[15:0];
  assign unused_dout = noc_dout_i;
  assign cnt_inc     = cnt_q + 1'b1;

  function automatic logic [37:0] resp_flit(input logic [NODE_W-1:0] dst,
                                            input logic [15:0]       data);
    logic [37:0] f;
    f = '0;
    f[FLIT_W-1:0] = {OWN_NODE, dst, data};
    return f;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // (no latches); the defaults hold state or keep pulses low.
    state_d  = state_q;
    orig_d   = orig_q;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    adr_d    = adr_q;
    sel_d    = sel_q;
    we_d     = we_q;
    dat_d    = dat_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    din_d    = din_q;
    noc_rd_o = 1'b0;
    noc_wr_o = 1'b0;

    case (state_q)
      RX_CMD, RX_ALO, RX_AHI, RX_DLO, RX_DHI: begin
        // The router needs one cycle after a pop before noc_nd_i is valid again.
        if (noc_nd_i && !gap_q) begin
          noc_rd_o = 1'b1;
          // A flit from a different origin means the old requester went away:
          // drop its partial request and treat this flit as a fresh CMD.
          if (state_q == RX_CMD || in_orig != orig_q) begin
            orig_d  = in_orig;
            we_d    = in_data[0];
            sel_d   = in_data[4:1];
            state_d = RX_ALO;
          end else if (state_q == RX_ALO) begin
            adr_d[15:0] = in_data;
            state_d     = RX_AHI;
          end else if (state_q == RX_AHI) begin
            adr_d[31:16] = in_data;
            if (we_q) begin
              state_d = RX_DLO;
            end else begin
              cyc_d   = 1'b1;
              stb_d   = 1'b1;
              cnt_d   = '0;
              state_d = WB;
            end
          end else if (state_q == RX_DLO) begin
            dat_d[15:0] = in_data;
            state_d     = RX_DHI;
          end else begin
            dat_d[31:16] = in_data;
            cyc_d        = 1'b1;
            stb_d        = 1'b1;
            cnt_d        = '0;
            state_d      = WB;
          end
        end
      end

      WB: begin
        // Ack is tested first so an ack on the timeout edge still counts as OK.
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          rdata_d = wb_dat_i;
          err_d   = 1'b0;
          din_d   = resp_flit(orig_q, STATUS_OK);
          state_d = TX_ST;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(WB_TIMEOUT)) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            rdata_d = '0;
            err_d   = 1'b1;
            din_d   = resp_flit(orig_q, STATUS_ERR);
            state_d = TX_ST;
          end
        end
      end

      TX_ST: begin
        if (!noc_wait_i && !gap_q) begin
          noc_wr_o = 1'b1;
          if (!err_q && !we_q) begin
            din_d   = resp_flit(orig_q, rdata_q[15:0]);
            state_d = TX_DLO;
          end else begin
            din_d   = '0;
            state_d = RX_CMD;
          end
        end
      end

      TX_DLO: begin
        if (!noc_wait_i && !gap_q) begin
          noc_wr_o = 1'b1;
          din_d    = resp_flit(orig_q, rdata_q[31:16]);
          state_d  = TX_DHI;
        end
      end

      TX_DHI: begin
        if (!noc_wait_i && !gap_q) begin
          noc_wr_o = 1'b1;
          din_d    = '0;
          state_d  = RX_CMD;
        end
      end

      default: state_d = RX_CMD;
    endcase

    gap_d = noc_rd_o | noc_wr_o;
  end

  // Single state register for the whole controller.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q <= RX_CMD;
      orig_q  <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      adr_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      din_q   <= '0;
      gap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      orig_q  <= orig_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      adr_q   <= adr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      gap_q   <= gap_d;
    end
  end

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_adr_o  = adr_q;
  assign wb_sel_o  = sel_q;
  assign wb_we_o   = we_q;
  assign wb_dat_o  = dat_q;
  assign noc_din_o = din_q;
  assign busy_o    = (state_q != RX_CMD);

endmodule

// File: tb/tb_rtsnoc_wishbone_master.sv
// -----------------------------------------------------------------------------
// tb_rtsnoc_wishbone_master
//   Router source, Wishbone slave and router sink models around the bridge.
//   Requests are described at packet level; the expected Wishbone transfer and
//   response flits are derived from the request fields and the slave latency.
// -----------------------------------------------------------------------------
module tb_rtsnoc_wishbone_master;

  localparam int TB_X    = 0;
  localparam int TB_Y    = 1;
  localparam int TB_L    = 5;
  localparam int TIMEOUT = 8;
  localparam logic [4:0] OWN_NODE = 5'(TB_X * 16 + TB_Y * 8 + TB_L);

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic [37:0] noc_din_o;
  logic        noc_wr_o, noc_rd_o, busy_o;
  logic [37:0] noc_dout_i = '0;
  logic        noc_wait_i = 1'b0;
  logic        noc_nd_i   = 1'b0;

  rtsnoc_wishbone_master #(
    .NOC_LOCAL_ADR(TB_L), .NOC_X(TB_X), .NOC_Y(TB_Y),
    .SOC_SIZE_X(1), .SOC_SIZE_Y(1), .WB_TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .noc_din_o(noc_din_o), .noc_wr_o(noc_wr_o), .noc_rd_o(noc_rd_o),
    .noc_dout_i(noc_dout_i), .noc_wait_i(noc_wait_i), .noc_nd_i(noc_nd_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] dat;
    int          exp_len;   // stb cycles expected, -1 = not checked
  } wb_exp_t;

  typedef struct {
    int          lat;       // stb cycles before ack, -1 = never
    logic [31:0] rdata;
  } slave_t;

  logic [37:0] rx_q[$];
  logic [37:0] exp_tx[$];
  wb_exp_t     exp_wb[$];
  slave_t      sl_q[$];

  int n_checks = 0;
  int n_err    = 0;
  bit hole_en    = 0;
  bit rand_wait  = 0;
  bit force_wait = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [37:0] req_flit(input logic [4:0] orig, input logic [15:0] d);
    return {12'b0, orig, OWN_NODE, d};
  endfunction

  function automatic logic [37:0] resp(input logic [4:0] dst, input logic [15:0] d);
    return {12'b0, OWN_NODE, dst, d};
  endfunction

  // Describe one request; the model derives transfer and response from it.
  task automatic add_request(input logic [4:0] node, input logic [15:0] cmd,
                             input logic [31:0] adr, input logic [31:0] dat,
                             input int lat, input logic [31:0] rdata,
                             input bit chk_len, input bit model_tx);
    bit ok;
    wb_exp_t e;
    ok = (lat >= 0) && (lat < TIMEOUT);
    rx_q.push_back(req_flit(node, cmd));
    rx_q.push_back(req_flit(node, adr[15:0]));
    rx_q.push_back(req_flit(node, adr[31:16]));
    if (cmd[0]) begin
      rx_q.push_back(req_flit(node, dat[15:0]));
      rx_q.push_back(req_flit(node, dat[31:16]));
    end
    e.adr = adr; e.sel = cmd[4:1]; e.we = cmd[0]; e.dat = dat;
    e.exp_len = !chk_len ? -1 : (ok ? lat + 1 : TIMEOUT);
    exp_wb.push_back(e);
    sl_q.push_back('{lat: lat, rdata: rdata});
    if (model_tx) begin
      exp_tx.push_back(resp(node, ok ? 16'h0001 : 16'h0002));
      if (ok && !cmd[0]) begin
        exp_tx.push_back(resp(node, rdata[15:0]));
        exp_tx.push_back(resp(node, rdata[31:16]));
      end
    end
  endtask

  // Router source, router sink and Wishbone slave, driven #1 after each edge.
  initial begin
    bit     pop;
    int     sl_cnt = 0;
    slave_t sl_cur = '{lat: -1, rdata: 32'h0};
    forever begin
      @(negedge clk_i);
      pop = noc_rd_o;
      @(posedge clk_i);
      #1;
      if (pop && rx_q.size() > 0) void'(rx_q.pop_front());
      noc_nd_i   = (rx_q.size() > 0) && (!hole_en || $urandom_range(3) != 0);
      noc_dout_i = (rx_q.size() > 0) ? rx_q[0] : '0;
      noc_wait_i = force_wait || (rand_wait && $urandom_range(2) == 0);
      if (wb_stb_o) begin
        if (sl_cnt == 0)
          sl_cur = (sl_q.size() > 0) ? sl_q.pop_front() : '{lat: -1, rdata: 32'h0};
        wb_ack_i = (sl_cur.lat == sl_cnt);
        wb_dat_i = sl_cur.rdata;
        sl_cnt++;
      end else begin
        sl_cnt   = 0;
        wb_ack_i = 1'b0;
        wb_dat_i = $urandom;
      end
    end
  end

  // Compare process: checks every cycle against the expectation queues.
  initial begin
    logic        prev_stb = 0, prev_ack = 0, prev_wr = 0, prev_rd = 0;
    logic [37:0] prev_din = '0;
    logic [31:0] held_adr = '0;
    logic [36:0] held_ctl = '0;
    int          stb_run  = 0;
    wb_exp_t     cur;
    cur.exp_len = -1;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        prev_stb = 0; prev_ack = 0; prev_wr = 0; prev_rd = 0;
        prev_din = '0; stb_run = 0;
      end else begin
        check("cyc_eq_stb", 64'(wb_cyc_o), 64'(wb_stb_o));
        if (wb_stb_o) begin
          check("busy_in_wb", 64'(busy_o), 64'(1));
          if (!prev_stb) begin
            check("wb_expected", 64'(exp_wb.size() > 0), 64'(1));
            if (exp_wb.size() > 0) begin
              cur = exp_wb.pop_front();
              check("wb_adr", 64'(wb_adr_o), 64'(cur.adr));
              check("wb_sel", 64'(wb_sel_o), 64'(cur.sel));
              check("wb_we",  64'(wb_we_o),  64'(cur.we));
              if (cur.we) check("wb_dat", 64'(wb_dat_o), 64'(cur.dat));
            end else begin
              cur.exp_len = -1;
            end
            held_adr = wb_adr_o;
            held_ctl = {wb_sel_o, wb_we_o, wb_dat_o};
            stb_run  = 0;
          end else begin
            check("wb_adr_hold", 64'(wb_adr_o), 64'(held_adr));
            check("wb_ctl_hold", 64'({wb_sel_o, wb_we_o, wb_dat_o}), 64'(held_ctl));
          end
          stb_run++;
          if (wb_ack_i && cur.exp_len >= 0)
            check("wb_len_ack", 64'(stb_run), 64'(cur.exp_len));
        end else if (prev_stb && !prev_ack && cur.exp_len >= 0) begin
          check("wb_len_timeout", 64'(stb_run), 64'(cur.exp_len));
        end
        if (noc_rd_o) begin
          check("rd_spacing", 64'(prev_rd), 64'(0));
          check("rd_valid", 64'(noc_nd_i), 64'(1));
        end
        if (noc_wr_o) begin
          check("wr_spacing", 64'(prev_wr), 64'(0));
          check("wr_wait", 64'(noc_wait_i), 64'(0));
          check("tx_expected", 64'(exp_tx.size() > 0), 64'(1));
          if (exp_tx.size() > 0) check("tx_flit", 64'(noc_din_o), 64'(exp_tx.pop_front()));
        end
        if (!prev_wr && prev_din != '0)
          check("din_hold", 64'(noc_din_o), 64'(prev_din));
        prev_stb = wb_stb_o; prev_ack = wb_ack_i; prev_wr = noc_wr_o;
        prev_rd  = noc_rd_o; prev_din = noc_din_o;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk_i);
      if (rx_q.size() == 0 && exp_tx.size() == 0 && exp_wb.size() == 0 && !busy_o)
        done = 1;
    end
    check("idle_reached", 64'(done), 64'(1));
  endtask

  task automatic wait_stb(input string name, input bit need_ack);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk_i);
      if (wb_stb_o && (!need_ack || wb_ack_i)) seen = 1;
    end
    check(name, 64'(seen), 64'(1));
  endtask

  initial begin
    int wr_in_window;

    // Reset state
    repeat (3) tick();
    @(negedge clk_i);
    check("rst_cyc", 64'(wb_cyc_o), 64'(0));
    check("rst_stb", 64'(wb_stb_o), 64'(0));
    check("rst_wr",  64'(noc_wr_o), 64'(0));
    check("rst_rd",  64'(noc_rd_o), 64'(0));
    check("rst_din", 64'(noc_din_o), 64'(0));
    check("rst_adr", 64'(wb_adr_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    tick();
    rst_i = 1'b0;

    // Write from (1,0,L2), ack after 3 stb cycles
    add_request(5'h12, 16'h001F, 32'h8000_0010, 32'hDEAD_BEEF, 3, 32'h0, 1, 0);
    exp_tx.push_back(38'h001B20001);
    wait_idle(400);

    // Read, slave returns 0x12345678
    add_request(5'h12, 16'h001E, 32'h8000_0020, 32'h0, 2, 32'h1234_5678, 1, 0);
    exp_tx.push_back(38'h001B20001);
    exp_tx.push_back(38'h001B25678);
    exp_tx.push_back(38'h001B21234);
    wait_idle(400);

    // Slave never acks: stb for exactly TIMEOUT cycles, ERR status only
    add_request(5'h12, 16'h001E, 32'h8000_0030, 32'h0, -1, 32'hFFFF_FFFF, 1, 0);
    exp_tx.push_back(38'h001B20002);
    wait_idle(400);

    // Ack on the same edge as the timeout: still OK with data
    add_request(5'h12, 16'h001E, 32'h0000_0040, 32'h0, TIMEOUT - 1, 32'hCAFE_F00D, 1, 0);
    exp_tx.push_back(38'h001B20001);
    exp_tx.push_back(38'h001B2F00D);
    exp_tx.push_back(38'h001B2CAFE);
    wait_idle(400);

    // TX backpressure for 10 cycles after the read completes
    force_wait = 1;
    add_request(5'h12, 16'h001E, 32'h0000_0100, 32'h0, 1, 32'hA5A5_5A5A, 1, 0);
    exp_tx.push_back(38'h001B20001);
    exp_tx.push_back(38'h001B25A5A);
    exp_tx.push_back(38'h001B2A5A5);
    wait_stb("bp_ack_seen", 1);
    wr_in_window = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (noc_wr_o) wr_in_window++;
    end
    check("bp_no_wr", 64'(wr_in_window), 64'(0));
    check("bp_pending", 64'(exp_tx.size()), 64'(3));
    force_wait = 0;
    wait_idle(400);

    // Origin switch: partial request from (0,1,L0) dropped, (1,1,L3) served
    rx_q.push_back(req_flit(5'h08, 16'h001E));
    rx_q.push_back(req_flit(5'h08, 16'h0040));
    add_request(5'h1B, 16'h0007, 32'h0000_0044, 32'h1122_3344, 1, 32'h0, 1, 0);
    exp_tx.push_back(38'h001BB0001);
    wait_idle(400);

    // Reset while stb is high: no response, next request served
    add_request(5'h12, 16'h001E, 32'h0000_0300, 32'h0, -1, 32'h0, 0, 0);
    wait_stb("rst_stb_seen", 0);
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("midrst_cyc", 64'(wb_cyc_o), 64'(0));
    check("midrst_stb", 64'(wb_stb_o), 64'(0));
    check("midrst_wr",  64'(noc_wr_o), 64'(0));
    check("midrst_busy", 64'(busy_o), 64'(0));
    add_request(5'h12, 16'h0003, 32'h0000_0004, 32'h0000_0055, 0, 32'h0, 1, 0);
    exp_tx.push_back(38'h001B20001);
    wait_idle(400);

    // Randomized traffic with flit holes and random backpressure
    hole_en   = 1;
    rand_wait = 1;
    for (int i = 0; i < 24; i++) begin
      logic [4:0]  node;
      logic        we;
      logic [3:0]  sel;
      logic [15:0] cmd;
      int          lat;
      node = 5'($urandom_range(31));
      we   = 1'($urandom_range(1));
      sel  = 4'($urandom_range(15));
      cmd  = {11'($urandom), sel, we};
      lat  = ($urandom_range(5) == 0) ? -1 : int'($urandom_range(TIMEOUT - 1));
      add_request(node, cmd, $urandom, $urandom, lat, $urandom, 1, 1);
    end
    wait_idle(8000);
    hole_en   = 0;
    rand_wait = 0;

    check("end_busy", 64'(busy_o), 64'(0));
    check("end_tx_left", 64'(exp_tx.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
